// File: rtl/ahb_apb_bridge_core_if.sv
// AHB-to-APB bridge signal bundle.
// Carries the AHB slave-side signals (Htrans, Hwrite, Hreadyin, Haddr, Hwdata, Hsize, Hburst,
// Hreadyout, Hresp, Hrdata) and the APB master-side signals (Pselx, Penable, Pwrite, Paddr,
// Pwdata, Prdata).
//   slave  : view used by the bridge core (drives Hready/Hresp/Hrdata and all APB outputs)
//   master : view used by the surrounding system / AHB driver and APB peripherals
interface ahb_apb_bridge_core_if #(
  parameter int unsigned NUM_SLV = 3
);
  logic [1:0]         Htrans;
  logic               Hwrite;
  logic               Hreadyin;
  logic [31:0]        Haddr;
  logic [31:0]        Hwdata;
  logic [2:0]         Hsize;
  logic [2:0]         Hburst;
  logic               Hreadyout;
  logic [1:0]         Hresp;
  logic [31:0]        Hrdata;
  logic [31:0]        Prdata;
  logic [NUM_SLV-1:0] Pselx;
  logic               Penable;
  logic               Pwrite;
  logic [31:0]        Paddr;
  logic [31:0]        Pwdata;

  modport slave (
    input  Htrans, Hwrite, Hreadyin, Haddr, Hwdata, Hsize, Hburst, Prdata,
    output Hreadyout, Hresp, Hrdata, Pselx, Penable, Pwrite, Paddr, Pwdata
  );

  modport master (
    output Htrans, Hwrite, Hreadyin, Haddr, Hwdata, Hsize, Hburst, Prdata,
    input  Hreadyout, Hresp, Hrdata, Pselx, Penable, Pwrite, Paddr, Pwdata
  );
endinterface

// File: rtl/ahb_apb_bridge_core.sv
// AHB-slave to APB-master conversion core.
// Accepts single AHB transfers that fall inside the bridge window and replays each one as an
// APB SETUP + ENABLE access to one of NUM_SLV peripherals, stalling AHB through Hreadyout.
// Ports:
//   clock   : bridge clock
//   Hresetn : asynchronous active-low reset
//   bus     : ahb_apb_bridge_core_if.slave (AHB inputs, APB outputs, Hready/Hresp/Hrdata)
module ahb_apb_bridge_core #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned REGION_BITS = 26,
  parameter int unsigned NUM_SLV     = 3
) (
  input logic                 clock,
  input logic                 Hresetn,
  ahb_apb_bridge_core_if.slave bus
);

  localparam int unsigned IdxW    = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [32:0] WinSize = 33'(NUM_SLV) << REGION_BITS;

  typedef enum logic [1:0] {StIdle, StWwait, StSetup, StEnable} state_e;

  state_e             state_q, state_d;
  logic [NUM_SLV-1:0] pselx_q, pselx_d;
  logic               penable_q, penable_d;
  logic               hready_q, hready_d;
  logic               pwrite_q, pwrite_d;
  logic [31:0]        paddr_q, paddr_d;
  logic [31:0]        pwdata_q, pwdata_d;
  logic [IdxW-1:0]    idx_q, idx_d;

  logic [31:0]        offset;
  logic               in_window;
  logic               valid;
  logic [IdxW-1:0]    hidx;
  logic               unused_inputs;

  function automatic logic [NUM_SLV-1:0] onehot(input logic [IdxW-1:0] idx);
    logic [NUM_SLV-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      oh[i] = (32'(idx) == i);
    end
    return oh;
  endfunction

  // The 33-bit compare keeps the window check correct even if BASE_ADDR + window wraps.
  assign offset    = bus.Haddr - BASE_ADDR;
  assign in_window = (bus.Haddr >= BASE_ADDR) && ({1'b0, offset} < WinSize);
  assign valid     = bus.Hreadyin && bus.Htrans[1] && in_window;
  assign hidx      = offset[REGION_BITS +: IdxW];

  assign unused_inputs = ^{bus.Hsize, bus.Hburst};

  always_comb begin
    state_d   = state_q;
    pselx_d   = pselx_q;
    penable_d = 1'b0;
    hready_d  = hready_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    idx_d     = idx_q;
    unique case (state_q)
      // ENABLE completes the data phase, so it can accept a pipelined transfer like IDLE.
      StIdle, StEnable: begin
        if (valid) begin
          paddr_d  = bus.Haddr;
          pwrite_d = bus.Hwrite;
          idx_d    = hidx;
          hready_d = 1'b0;
          if (bus.Hwrite) begin
            state_d = StWwait;
            pselx_d = '0;
          end else begin
            state_d = StSetup;
            pselx_d = onehot(hidx);
          end
        end else begin
          state_d  = StIdle;
          pselx_d  = '0;
          hready_d = 1'b1;
        end
      end
      StWwait: begin
        pwdata_d = bus.Hwdata;
        state_d  = StSetup;
        pselx_d  = onehot(idx_q);
        hready_d = 1'b0;
      end
      StSetup: begin
        state_d   = StEnable;
        penable_d = 1'b1;
        hready_d  = 1'b1;
      end
      default: begin
        state_d  = StIdle;
        pselx_d  = '0;
        hready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q   <= StIdle;
      pselx_q   <= '0;
      penable_q <= 1'b0;
      hready_q  <= 1'b1;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      pselx_q   <= pselx_d;
      penable_q <= penable_d;
      hready_q  <= hready_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      idx_q     <= idx_d;
    end
  end

  assign bus.Pselx     = pselx_q;
  assign bus.Penable   = penable_q;
  assign bus.Hreadyout = hready_q;
  assign bus.Pwrite    = pwrite_q;
  assign bus.Paddr     = paddr_q;
  assign bus.Pwdata    = pwdata_q;
  assign bus.Hresp     = 2'b00;
  assign bus.Hrdata    = bus.Prdata;

endmodule

// File: tb/tb_ahb_apb_bridge_core.sv
// Testbench for ahb_apb_bridge_core: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level latency model.
module tb_ahb_apb_bridge_core;

  localparam logic [31:0] Base    = 32'h8000_0000;
  localparam logic [31:0] WinEnd  = 32'h8C00_0000;
  localparam int          KIdle   = 0;
  localparam int          KWait   = 1;
  localparam int          KSetup  = 2;
  localparam int          KEnable = 3;

  logic clock;
  logic Hresetn;
  int   n_checks;
  int   n_errors;

  ahb_apb_bridge_core_if #(.NUM_SLV(3)) bus ();

  ahb_apb_bridge_core #(
    .BASE_ADDR   (Base),
    .REGION_BITS (26),
    .NUM_SLV     (3)
  ) dut (
    .clock   (clock),
    .Hresetn (Hresetn),
    .bus     (bus)
  );

  assign bus.Hreadyin = bus.Hreadyout;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted transfer expands into its cycle frames (write: WAIT SETUP ENABLE,
  // read: SETUP ENABLE); with no frames pending the bridge shows an IDLE frame.
  int          cur;
  int          sched[$];
  logic [31:0] m_addr;
  logic [31:0] m_pwdata;
  logic        m_write;
  int          m_idx;

  function automatic bit in_win(input logic [31:0] a);
    return (a >= Base) && (a < WinEnd);
  endfunction

  initial begin
    cur = KIdle; m_addr = '0; m_pwdata = '0; m_write = 1'b0; m_idx = 0;
    forever begin
      @(posedge clock or negedge Hresetn);
      if (!Hresetn) begin
        cur = KIdle; sched.delete(); m_addr = '0; m_pwdata = '0; m_write = 1'b0; m_idx = 0;
      end else begin
        bit ready;
        ready = (cur == KIdle) || (cur == KEnable);
        if (cur == KWait) m_pwdata = bus.Hwdata;
        if (sched.size() > 0) begin
          cur = sched.pop_front();
        end else if (ready && bus.Htrans[1] && in_win(bus.Haddr)) begin
          m_addr  = bus.Haddr;
          m_write = bus.Hwrite;
          m_idx   = int'((bus.Haddr - Base) / 32'h0400_0000);
          if (bus.Hwrite) begin
            cur = KWait; sched.push_back(KSetup); sched.push_back(KEnable);
          end else begin
            cur = KSetup; sched.push_back(KEnable);
          end
        end else begin
          cur = KIdle;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      begin
        logic [2:0] exp_sel;
        exp_sel = ((cur == KSetup) || (cur == KEnable)) ? 3'(1 << m_idx) : 3'b000;
        check("m_pselx", 32'(bus.Pselx), 32'(exp_sel));
        check("m_penable", 32'(bus.Penable), 32'(cur == KEnable));
        check("m_hready", 32'(bus.Hreadyout), 32'((cur == KIdle) || (cur == KEnable)));
        check("m_hresp", 32'(bus.Hresp), 32'h0);
        check("m_paddr", bus.Paddr, m_addr);
        check("m_pwrite", 32'(bus.Pwrite), 32'(m_write));
        check("m_pwdata", bus.Pwdata, m_pwdata);
        if (cur == KEnable && !m_write) check("m_hrdata", bus.Hrdata, bus.Prdata);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] tr, input logic wr, input logic [31:0] a);
    bus.Htrans = tr;
    bus.Hwrite = wr;
    bus.Haddr  = a;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 6))
      0, 1, 2: a = Base + ($urandom_range(0, 2) << 26) + ($urandom & 32'h03FF_FFFC);
      3:       a = 32'h7FFF_FFFC;
      4:       a = 32'h8C00_0000;
      5:       a = 32'h8BFF_FFFC;
      default: a = $urandom;
    endcase
    return a;
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    Hresetn  = 1'b0;
    drive(2'b00, 1'b0, 32'h0);
    bus.Hwdata = '0;
    bus.Prdata = '0;
    bus.Hsize  = 3'b010;
    bus.Hburst = 3'b000;

    // Reset values.
    repeat (2) @(negedge clock);
    check("rst_pselx", 32'(bus.Pselx), 32'h0);
    check("rst_penable", 32'(bus.Penable), 32'h0);
    check("rst_hready", 32'(bus.Hreadyout), 32'h1);
    check("rst_paddr", bus.Paddr, 32'h0);
    check("rst_pwdata", bus.Pwdata, 32'h0);
    check("rst_pwrite", 32'(bus.Pwrite), 32'h0);
    #1 Hresetn = 1'b1;

    // Single read.
    step(); drive(2'b10, 1'b0, 32'h8000_0010); bus.Prdata = 32'hCAFE_F00D;
    step(); drive(2'b00, 1'b0, 32'h0);
    @(negedge clock);
    check("rd_setup_pselx", 32'(bus.Pselx), 32'h1);
    check("rd_setup_penable", 32'(bus.Penable), 32'h0);
    check("rd_setup_hready", 32'(bus.Hreadyout), 32'h0);
    check("rd_paddr", bus.Paddr, 32'h8000_0010);
    step(); @(negedge clock);
    check("rd_en_penable", 32'(bus.Penable), 32'h1);
    check("rd_en_hready", 32'(bus.Hreadyout), 32'h1);
    check("rd_en_hrdata", bus.Hrdata, 32'hCAFE_F00D);
    step(); @(negedge clock);
    check("rd_done_pselx", 32'(bus.Pselx), 32'h0);

    // Single write.
    step(); drive(2'b10, 1'b1, 32'h8400_0004);
    step(); drive(2'b00, 1'b0, 32'h0); bus.Hwdata = 32'h1234_5678;
    @(negedge clock);
    check("wr_wait_pselx", 32'(bus.Pselx), 32'h0);
    check("wr_wait_hready", 32'(bus.Hreadyout), 32'h0);
    step(); @(negedge clock);
    check("wr_setup_pselx", 32'(bus.Pselx), 32'h2);
    check("wr_setup_pwrite", 32'(bus.Pwrite), 32'h1);
    check("wr_setup_pwdata", bus.Pwdata, 32'h1234_5678);
    check("wr_setup_hready", 32'(bus.Hreadyout), 32'h0);
    step(); @(negedge clock);
    check("wr_en_penable", 32'(bus.Penable), 32'h1);
    check("wr_en_hready", 32'(bus.Hreadyout), 32'h1);

    // Back-to-back: read, then a write presented through its ENABLE cycle.
    step(); drive(2'b10, 1'b0, 32'h8800_0000);
    step(); drive(2'b10, 1'b1, 32'h8000_0020);
    @(negedge clock);
    check("b2b_setup_pselx", 32'(bus.Pselx), 32'h4);
    step(); @(negedge clock);
    check("b2b_en_penable", 32'(bus.Penable), 32'h1);
    check("b2b_en_hready", 32'(bus.Hreadyout), 32'h1);
    step(); drive(2'b00, 1'b0, 32'h0); bus.Hwdata = 32'hA5A5_0001;
    @(negedge clock);
    check("b2b_wait_hready", 32'(bus.Hreadyout), 32'h0);
    check("b2b_wait_pselx", 32'(bus.Pselx), 32'h0);
    check("b2b_wait_paddr", bus.Paddr, 32'h8000_0020);
    step(); @(negedge clock);
    check("b2b_setup2_pselx", 32'(bus.Pselx), 32'h1);
    check("b2b_setup2_pwdata", bus.Pwdata, 32'hA5A5_0001);
    step(); @(negedge clock);
    check("b2b_en2_penable", 32'(bus.Penable), 32'h1);

    // Out of window, BUSY and IDLE are all ignored.
    step(); drive(2'b10, 1'b0, 32'h7FFF_FFFC);
    step(); drive(2'b10, 1'b1, 32'h8C00_0000);
    @(negedge clock);
    check("oow_lo_pselx", 32'(bus.Pselx), 32'h0);
    check("oow_lo_hready", 32'(bus.Hreadyout), 32'h1);
    step(); drive(2'b01, 1'b0, 32'h8000_0000);
    @(negedge clock);
    check("oow_hi_pselx", 32'(bus.Pselx), 32'h0);
    check("oow_hi_hresp", 32'(bus.Hresp), 32'h0);
    step(); drive(2'b00, 1'b1, 32'h8400_0000);
    @(negedge clock);
    check("busy_hready", 32'(bus.Hreadyout), 32'h1);
    step(); drive(2'b00, 1'b0, 32'h0);
    @(negedge clock);
    check("idle_pselx", 32'(bus.Pselx), 32'h0);

    // Reset during SETUP.
    step(); drive(2'b10, 1'b0, 32'h8000_0010);
    step(); drive(2'b00, 1'b0, 32'h0);
    @(negedge clock);
    check("mrst_pre_pselx", 32'(bus.Pselx), 32'h1);
    #1 Hresetn = 1'b0;
    #1;
    check("mrst_pselx", 32'(bus.Pselx), 32'h0);
    check("mrst_penable", 32'(bus.Penable), 32'h0);
    check("mrst_hready", 32'(bus.Hreadyout), 32'h1);
    check("mrst_paddr", bus.Paddr, 32'h0);
    @(negedge clock);
    #1 Hresetn = 1'b1;
    step(); @(negedge clock);
    check("mrst_no_enable", 32'(bus.Penable), 32'h0);
    check("mrst_idle_pselx", 32'(bus.Pselx), 32'h0);

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 2000; i++) begin
      step();
      Hresetn    = ($urandom_range(0, 79) != 0);
      drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rand_addr());
      bus.Hwdata = $urandom;
      bus.Prdata = $urandom;
    end

    step(); Hresetn = 1'b1; drive(2'b00, 1'b0, 32'h0);
    repeat (5) step();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
